// File: rtl/l1_veri_yanitlayici.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache (responder side).
// Misses refill a 4-word line; every write is posted to backing memory.
module l1_veri_yanitlayici #(
    parameter int SATIR_SAYISI = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cek_sec_n_i,
    input  logic        cek_yaz_gecerli_i,
    input  logic [31:0] cek_adr_i,
    input  logic [31:0] cek_veri_i,
    input  logic [3:0]  cek_veri_maske_i,
    output logic [31:0] cek_veri_o,
    output logic        cek_durdur_o,
    output logic        ab_istek_o,
    output logic        ab_yaz_o,
    output logic [31:0] ab_adr_o,
    output logic [31:0] ab_veri_o,
    output logic [3:0]  ab_maske_o,
    input  logic        ab_kabul_i,
    input  logic [31:0] ab_veri_i,
    input  logic        ab_gecerli_i
);
    localparam int IDX_W = $clog2(SATIR_SAYISI);
    localparam int TAG_W = 28 - IDX_W;

    typedef enum logic [2:0] {
        BOSTA, ETIKET, DOLDUR_ISTEK, DOLDUR_BEKLE, YAZ_ISTEK, YANIT
    } durum_t;

    durum_t durum;

    logic [SATIR_SAYISI-1:0] gecerli;
    logic [TAG_W-1:0]        etiket [SATIR_SAYISI];
    logic [31:0]             veri   [SATIR_SAYISI][4];

    logic [31:2] istek_adr;
    logic [31:0] istek_veri;
    logic [3:0]  istek_maske;
    logic        istek_yaz;
    logic [1:0]  vurus;

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [1:0]       ofs;
    logic             isabet;
    logic             unused_adr_bits;

    assign idx    = istek_adr[4+IDX_W-1:4];
    assign tag    = istek_adr[31:4+IDX_W];
    assign ofs    = istek_adr[3:2];
    assign isabet = gecerli[idx] && (etiket[idx] == tag);

    // Byte offset bits are never used: the interface is word-granular.
    assign unused_adr_bits = &{1'b0, cek_adr_i[1:0]};

    assign cek_durdur_o = !rst_i && !cek_sec_n_i && (durum != YANIT);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            durum       <= BOSTA;
            gecerli     <= '0;
            vurus       <= 2'd0;
            istek_adr   <= '0;
            istek_veri  <= '0;
            istek_maske <= '0;
            istek_yaz   <= 1'b0;
            cek_veri_o  <= '0;
            ab_istek_o  <= 1'b0;
            ab_yaz_o    <= 1'b0;
            ab_adr_o    <= '0;
            ab_veri_o   <= '0;
            ab_maske_o  <= '0;
        end else begin
            case (durum)
                BOSTA: begin
                    if (!cek_sec_n_i) begin
                        istek_adr   <= cek_adr_i[31:2];
                        istek_veri  <= cek_veri_i;
                        istek_maske <= cek_veri_maske_i;
                        istek_yaz   <= cek_yaz_gecerli_i;
                        durum       <= ETIKET;
                    end
                end
                ETIKET: begin
                    if (istek_yaz) begin
                        if (isabet) begin
                            for (int b = 0; b < 4; b++) begin
                                if (istek_maske[b]) begin
                                    veri[idx][ofs][8*b +: 8] <= istek_veri[8*b +: 8];
                                end
                            end
                        end
                        ab_istek_o <= 1'b1;
                        ab_yaz_o   <= 1'b1;
                        ab_adr_o   <= {istek_adr, 2'b00};
                        ab_veri_o  <= istek_veri;
                        ab_maske_o <= istek_maske;
                        durum      <= YAZ_ISTEK;
                    end else if (isabet) begin
                        cek_veri_o <= veri[idx][ofs];
                        durum      <= YANIT;
                    end else begin
                        // The line is overwritten beat by beat, so drop it now.
                        gecerli[idx] <= 1'b0;
                        vurus        <= 2'd0;
                        ab_istek_o   <= 1'b1;
                        ab_yaz_o     <= 1'b0;
                        ab_adr_o     <= {istek_adr[31:4], 4'b0000};
                        durum        <= DOLDUR_ISTEK;
                    end
                end
                DOLDUR_ISTEK: begin
                    if (ab_kabul_i) begin
                        ab_istek_o <= 1'b0;
                        durum      <= DOLDUR_BEKLE;
                    end
                end
                DOLDUR_BEKLE: begin
                    if (ab_gecerli_i) begin
                        veri[idx][vurus] <= ab_veri_i;
                        vurus            <= vurus + 2'd1;
                        if (vurus == 2'd3) begin
                            gecerli[idx] <= 1'b1;
                            etiket[idx]  <= tag;
                            cek_veri_o   <= (ofs == 2'd3) ? ab_veri_i : veri[idx][ofs];
                            durum        <= YANIT;
                        end
                    end
                end
                YAZ_ISTEK: begin
                    if (ab_kabul_i) begin
                        ab_istek_o <= 1'b0;
                        durum      <= YANIT;
                    end
                end
                YANIT:   durum <= BOSTA;
                default: durum <= BOSTA;
            endcase
        end
    end
endmodule

// File: tb/tb_l1_veri_yanitlayici.sv
// Bench for l1_veri_yanitlayici: directed table, reset-mid-refill sequence and
// random traffic checked against a line-presence model plus a backing memory.
module tb_l1_veri_yanitlayici;
    localparam int N = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cek_sec_n = 1'b1;
    logic        cek_yaz = 1'b0;
    logic [31:0] cek_adr = '0;
    logic [31:0] cek_veri = '0;
    logic [3:0]  cek_maske = '0;
    logic [31:0] cek_veri_o;
    logic        cek_durdur_o;
    logic        ab_istek_o, ab_yaz_o;
    logic [31:0] ab_adr_o, ab_veri_o;
    logic [3:0]  ab_maske_o;
    logic        ab_kabul = 1'b0;
    logic [31:0] ab_veri = '0;
    logic        ab_gecerli = 1'b0;

    int tests = 0;
    int fails = 0;

    logic [31:0] mem [logic [31:0]];
    bit          ref_v    [N];
    logic [31:0] ref_line [N];

    typedef struct {
        bit          yaz;
        logic [31:0] adr;
        logic [31:0] veri;
        logic [3:0]  maske;
        int          kind;
        logic [31:0] exp_data;
    } vec_t;

    always #5 clk = ~clk;

    l1_veri_yanitlayici #(.SATIR_SAYISI(N)) dut (
        .clk_i(clk), .rst_i(rst),
        .cek_sec_n_i(cek_sec_n), .cek_yaz_gecerli_i(cek_yaz),
        .cek_adr_i(cek_adr), .cek_veri_i(cek_veri), .cek_veri_maske_i(cek_maske),
        .cek_veri_o(cek_veri_o), .cek_durdur_o(cek_durdur_o),
        .ab_istek_o(ab_istek_o), .ab_yaz_o(ab_yaz_o), .ab_adr_o(ab_adr_o),
        .ab_veri_o(ab_veri_o), .ab_maske_o(ab_maske_o),
        .ab_kabul_i(ab_kabul), .ab_veri_i(ab_veri), .ab_gecerli_i(ab_gecerli)
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (mem.exists(w)) return mem[w];
        return w ^ 32'hA5A5_0000;
    endfunction

    function automatic void mem_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        logic [31:0] cur;
        cur = mem_rd(a);
        for (int b = 0; b < 4; b++) if (m[b]) cur[8*b +: 8] = d[8*b +: 8];
        mem[{a[31:2], 2'b00}] = cur;
    endfunction

    // 0 = hit (no backing traffic), 1 = line refill, 2 = posted write.
    function automatic int model_kind(input bit yaz, input logic [31:0] adr);
        int i;
        i = int'((adr >> 4) % N);
        if (yaz) return 2;
        if (ref_v[i] && ref_line[i] == {adr[31:4], 4'b0000}) return 0;
        return 1;
    endfunction

    function automatic void model_update(input bit yaz, input logic [31:0] adr);
        int i;
        i = int'((adr >> 4) % N);
        if (!yaz) begin
            ref_v[i]    = 1'b1;
            ref_line[i] = {adr[31:4], 4'b0000};
        end
    endfunction

    // Called at a negedge; plays both the core and the backing memory.
    task automatic apply_stimulus(input bit yaz, input logic [31:0] adr, input logic [31:0] veri,
                                  input logic [3:0] maske, input int exp_kind,
                                  input logic [31:0] exp_data, input int kabul_wait, input bit gaps);
        int cyc = 0, seen_kind = 0, wait_left = kabul_wait, beats = 0, gap_cycles = 0, stall_exp;
        bit done = 0, beat_phase = 0;
        logic [31:0] line;
        line = {adr[31:4], 4'b0000};
        cek_sec_n = 1'b0; cek_yaz = yaz; cek_adr = adr; cek_veri = veri; cek_maske = maske;
        while (!done && cyc < 200) begin
            #1;
            if (!cek_durdur_o) begin
                done = 1;
            end else begin
                ab_kabul = 1'b0; ab_gecerli = 1'b0;
                if (ab_istek_o) begin
                    if (seen_kind == 0) begin
                        seen_kind = ab_yaz_o ? 2 : 1;
                        if (ab_yaz_o) begin
                            check_output("write adr", ab_adr_o, {adr[31:2], 2'b00});
                            check_output("write data", ab_veri_o, veri);
                            check_output("write mask", {28'd0, ab_maske_o}, {28'd0, maske});
                        end else begin
                            check_output("refill adr", ab_adr_o, line);
                        end
                    end
                    if (wait_left == 0) begin
                        ab_kabul = 1'b1;
                        if (yaz) mem_write(adr, veri, maske);
                        else beat_phase = 1;
                    end else begin
                        wait_left--;
                    end
                end else if (beat_phase) begin
                    if (gaps && $urandom_range(0, 2) == 0) begin
                        gap_cycles++;
                    end else begin
                        ab_gecerli = 1'b1;
                        ab_veri = mem_rd(line + 32'(4 * (beats % 4)));
                        beats++;
                    end
                end
                cyc++;
                @(negedge clk);
            end
        end
        ab_kabul = 1'b0; ab_gecerli = 1'b0;
        if (!done) check_output("response timeout", 32'd0, 32'd1);
        case (exp_kind)
            0:       stall_exp = 2;
            1:       stall_exp = 2 + kabul_wait + 1 + 4 + gap_cycles;
            default: stall_exp = 2 + kabul_wait + 1;
        endcase
        check_output("backing request kind", 32'(seen_kind), 32'(exp_kind));
        check_output("stall cycles", 32'(cyc), 32'(stall_exp));
        if (!yaz) check_output("read data", cek_veri_o, exp_data);
        cek_sec_n = 1'b1;
        #1 check_output("stall idle", {31'd0, cek_durdur_o}, 32'd0);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, " cek_veri"}, cek_veri_o, 32'd0);
        check_output({tag, " ab_istek"}, {31'd0, ab_istek_o}, 32'd0);
        check_output({tag, " ab_yaz"}, {31'd0, ab_yaz_o}, 32'd0);
        check_output({tag, " ab_adr"}, ab_adr_o, 32'd0);
        check_output({tag, " ab_veri"}, ab_veri_o, 32'd0);
        check_output({tag, " ab_maske"}, {28'd0, ab_maske_o}, 32'd0);
        check_output({tag, " stall"}, {31'd0, cek_durdur_o}, 32'd0);
    endtask

    initial begin
        vec_t vecs [11];
        vecs[0]  = '{0, 32'h0000_0100, 32'h0,         4'h0, 1, 32'hCAFE_0000};
        vecs[1]  = '{0, 32'h0000_0104, 32'h0,         4'h0, 0, 32'hCAFE_0001};
        vecs[2]  = '{1, 32'h0000_0108, 32'h1234_5678, 4'h3, 2, 32'h0};
        vecs[3]  = '{0, 32'h0000_0108, 32'h0,         4'h0, 0, 32'hCAFE_5678};
        vecs[4]  = '{1, 32'h0000_0104, 32'hFFFF_FFFF, 4'h0, 2, 32'h0};
        vecs[5]  = '{0, 32'h0000_0104, 32'h0,         4'h0, 0, 32'hCAFE_0001};
        vecs[6]  = '{0, 32'h0000_0500, 32'h0,         4'h0, 1, 32'hA5A5_0500};
        vecs[7]  = '{0, 32'h0000_0100, 32'h0,         4'h0, 1, 32'hCAFE_0000};
        vecs[8]  = '{1, 32'h0000_2000, 32'hDEAD_BEEF, 4'hF, 2, 32'h0};
        vecs[9]  = '{0, 32'h0000_2000, 32'h0,         4'h0, 1, 32'hDEAD_BEEF};
        vecs[10] = '{0, 32'h0000_010C, 32'h0,         4'h0, 0, 32'hCAFE_0003};

        for (int k = 0; k < 4; k++) mem[32'h100 + 32'(4 * k)] = 32'hCAFE_0000 + 32'(k);
        for (int i = 0; i < N; i++) ref_v[i] = 1'b0;

        repeat (3) @(negedge clk);
        #1 check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            apply_stimulus(vecs[i].yaz, vecs[i].adr, vecs[i].veri, vecs[i].maske,
                           vecs[i].kind, vecs[i].exp_data, i % 3, i[0]);
            model_update(vecs[i].yaz, vecs[i].adr);
        end

        // Evict 0x100, then abandon its refill with a reset after two beats.
        apply_stimulus(0, 32'h500, 32'h0, 4'h0, 1, 32'hA5A5_0500, 0, 0);
        model_update(0, 32'h500);
        begin
            int guard = 0;
            cek_sec_n = 1'b0; cek_yaz = 1'b0; cek_adr = 32'h100;
            #1;
            while (!ab_istek_o && guard < 10) begin
                @(negedge clk); #1; guard++;
            end
            check_output("reset seq refill request", {31'd0, ab_istek_o}, 32'd1);
            ab_kabul = 1'b1;
            @(negedge clk); ab_kabul = 1'b0;
            for (int k = 0; k < 2; k++) begin
                ab_gecerli = 1'b1; ab_veri = 32'h7777_0000 + 32'(k);
                @(negedge clk);
            end
            rst = 1'b1; ab_veri = 32'h7777_0002;
            #1 check_output("stall during reset", {31'd0, cek_durdur_o}, 32'd0);
            @(negedge clk);
            #1 check_reset_outputs("mid-refill reset");
            rst = 1'b0; cek_sec_n = 1'b1; ab_veri = 32'h7777_0003;
            @(negedge clk);
            ab_gecerli = 1'b0;
            @(negedge clk);
            for (int i = 0; i < N; i++) ref_v[i] = 1'b0;
        end
        apply_stimulus(0, 32'h100, 32'h0, 4'h0, 1, 32'hCAFE_0000, 1, 1);
        model_update(0, 32'h100);
        apply_stimulus(0, 32'h500, 32'h0, 4'h0, 1, 32'hA5A5_0500, 0, 0);
        model_update(0, 32'h500);

        for (int n = 0; n < 150; n++) begin
            bit          yaz;
            logic [31:0] adr, veri;
            logic [3:0]  maske;
            int          kind;
            yaz   = ($urandom_range(0, 9) < 3);
            adr   = (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 7)) << 4)
                  | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            veri  = $urandom;
            maske = 4'($urandom_range(0, 15));
            kind  = model_kind(yaz, adr);
            apply_stimulus(yaz, adr, veri, maske, kind, mem_rd(adr),
                           int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            model_update(yaz, adr);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
